// File: rtl/count_direction_decoder_3bit.sv
// Recovers the up/down direction of a 3-bit stepping source from its sampled output,
// flagging illegal steps and wrap-around, and keeping a saturating error tally.
module count_direction_decoder_3bit #(
    parameter int unsigned LOCK_N = 2,
    parameter int unsigned ERR_W  = 4
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             sample_en,
    input  logic [2:0]       Q_in,
    output logic             locked,
    output logic             dir,
    output logic             dir_change,
    output logic             wrap,
    output logic             step_err,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {StIdle, StAcq, StLockUp, StLockDown} state_e;

    localparam logic [2:0] LockN = 3'(LOCK_N);

    state_e           r_state;
    logic [2:0]       r_prev;
    logic [2:0]       r_run;
    logic             r_cand;
    logic             r_dir;
    logic             r_locked;
    logic             r_dir_change;
    logic             r_wrap;
    logic             r_step_err;
    logic [ERR_W-1:0] r_err_count;

    logic [2:0]       w_delta;
    logic             w_up;
    logic             w_down;
    logic             w_legal;
    logic             w_wrap;
    logic [2:0]       w_run_next;
    logic [ERR_W-1:0] w_err_next;

    always_comb begin
        w_delta    = Q_in - r_prev;
        w_up       = (w_delta == 3'd1);
        w_down     = (w_delta == 3'd7);
        w_legal    = w_up | w_down;
        w_wrap     = (w_up && r_prev == 3'd7) || (w_down && r_prev == 3'd0);
        // A step that disagrees with the candidate restarts the run at one.
        w_run_next = (w_down == r_cand) ? r_run + 3'd1 : 3'd1;
        w_err_next = (r_err_count == {ERR_W{1'b1}}) ? r_err_count
                                                   : r_err_count + ERR_W'(1);
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state      <= StIdle;
            r_prev       <= 3'd0;
            r_run        <= 3'd0;
            r_cand       <= 1'b0;
            r_dir        <= 1'b0;
            r_locked     <= 1'b0;
            r_dir_change <= 1'b0;
            r_wrap       <= 1'b0;
            r_step_err   <= 1'b0;
            r_err_count  <= '0;
        end else begin
            r_dir_change <= 1'b0;
            r_wrap       <= 1'b0;
            r_step_err   <= 1'b0;
            if (sample_en) begin
                r_prev <= Q_in;
                case (r_state)
                    StIdle: begin
                        r_state <= StAcq;
                    end
                    StAcq: begin
                        if (w_legal) begin
                            r_wrap <= w_wrap;
                            r_cand <= w_down;
                            r_run  <= w_run_next;
                            if (w_run_next == LockN) begin
                                r_state  <= w_down ? StLockDown : StLockUp;
                                r_dir    <= w_down;
                                r_locked <= 1'b1;
                            end
                        end else begin
                            r_run       <= 3'd0;
                            r_step_err  <= 1'b1;
                            r_err_count <= w_err_next;
                        end
                    end
                    StLockUp, StLockDown: begin
                        if (w_legal) begin
                            r_wrap <= w_wrap;
                            if (w_down != r_dir) begin
                                r_state      <= w_down ? StLockDown : StLockUp;
                                r_dir        <= w_down;
                                r_dir_change <= 1'b1;
                            end
                        end else begin
                            // dir keeps its last value while reacquiring.
                            r_state     <= StAcq;
                            r_run       <= 3'd0;
                            r_locked    <= 1'b0;
                            r_step_err  <= 1'b1;
                            r_err_count <= w_err_next;
                        end
                    end
                    default: begin
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

    assign locked     = r_locked;
    assign dir        = r_dir;
    assign dir_change = r_dir_change;
    assign wrap       = r_wrap;
    assign step_err   = r_step_err;
    assign err_count  = r_err_count;

endmodule

// File: doc/count_direction_decoder_3bit.md
# count_direction_decoder_3bit

Receive-side companion to the 3-bit synchronous up/down counter. It samples the counter's 3-bit output each enabled clock and recovers the `sel` direction the counter was driven with. It also flags illegal transitions, reports wrap-around, and keeps a saturating error tally. It sits downstream of the counter, or any 3-bit stepping source, in monitor and self-check paths.

## Interface

Parameters:

- `LOCK_N`, default 2: consecutive same-direction legal steps needed to lock. Legal range 1..7.
- `ERR_W`, default 4: width of the saturating error counter.

Ports:

- `clk`  in  1: single clock; all state updates on the rising edge.
- `clear_n`  in  1: reset, asynchronous, active-low.
- `sample_en`  in  1: Q_in is valid and is sampled this cycle.
- `Q_in`  in  3: observed counter value.
- `locked`  out  1: direction is locked (state LOCK_UP or LOCK_DOWN).
- `dir`  out  1: recovered direction, 0 = up, 1 = down (same encoding as counter `sel`). Meaningful only when `locked` = 1.
- `dir_change`  out  1: one-cycle pulse when the locked direction flips.
- `wrap`  out  1: one-cycle pulse on a legal step 7→0 (up) or 0→7 (down).
- `step_err`  out  1: one-cycle pulse on an illegal step.
- `err_count`  out  ERR_W: count of illegal steps; saturates at all-ones.

## Operation

Sampling:

- Registers `prev[2:0]` and `run[2:0]`, candidate direction `cand`, and a 2-bit state.
- When `sample_en`=0, no state, register or counter changes; all pulses are 0.

Step classification, on `sample_en`=1 with a valid prev:

- `delta = (Q_in − prev) mod 8`.
- delta=1 is an UP step.
- delta=7 is a DOWN step.
- Any other delta, including 0, is ILLEGAL. The counter steps every clock, so a hold is an error.

Updates on every sample:

- `prev <= Q_in` on every sample in every state, including illegal steps.
- `wrap` pulses on UP with prev=7, or DOWN with prev=0. This applies in any state except IDLE.

States:

- **IDLE** (reset state):
  - On sample: capture prev, go to ACQ.
  - No step is evaluated and no pulses are produced.
- **ACQ**:
  - Legal step d with d==cand: `run <= run+1`.
  - Legal step d with d!=cand: `cand <= d`, `run <= 1`.
  - When the updated run equals LOCK_N: go to LOCK_UP or LOCK_DOWN per d, with `dir <= d`.
  - LOCK_N=1 therefore locks on the first legal step.
  - ILLEGAL: `run <= 0`, `step_err` pulse, stay in ACQ.
- **LOCK_UP / LOCK_DOWN**:
  - Same-direction step: stay.
  - Opposite step: move to the other LOCK state immediately, toggle `dir`, pulse `dir_change`. The counter's `sel` may change on any cycle.
  - ILLEGAL: go to ACQ, `run <= 0`, `step_err` pulse. `dir` holds its last value; `locked` drops.

Error counter:

- Increments by 1 on each `step_err`.
- Holds at 2^ERR_W−1 when saturated; it does not wrap.
- Cleared only by reset.

Reset:

- `clear_n`=0 immediately, asynchronously, forces:
  - state = IDLE
  - `prev`=0, `run`=0, `cand`=0
  - `dir`=0, `locked`=0, `dir_change`=0, `wrap`=0, `step_err`=0, `err_count`=0
- Deassertion mid-stream restarts in IDLE. The first post-reset sample is a capture only, never an error.

## Timing

- All outputs are registered.
- The response to a sample at edge N is visible after edge N, i.e. 1-cycle latency.
- `locked` rises in the cycle after the LOCK_N-th consistent step is sampled. It falls in the cycle after an illegal step.
- Each pulse is high for exactly one cycle per qualifying sample. Back-to-back qualifying samples give back-to-back pulses.
- Simultaneous events are all reported in the same cycle:
  - A direction flip across a wrap (e.g. locked UP, prev=0, Q_in=7) asserts `dir_change` and `wrap` together.
  - An illegal step with the counter at saturation asserts `step_err`; `err_count` stays at its maximum.
- Gaps in `sample_en` are transparent. Delta is computed against the last sampled value, not the last clock.

## Test plan

1. **Lock up:** reset, LOCK_N=2, feed 3,4,5,6 with `sample_en`=1.
   - `locked`=1 and `dir`=0 in the cycle after 5 is sampled.
   - No `step_err`.
2. **Down wrap:** locked DOWN, feed 1,0,7.
   - `wrap` pulses once, in the cycle after 7 is sampled.
   - `dir`=1 throughout.
3. **Direction flip:** locked UP at 5, feed 4.
   - `dir_change`=1 for one cycle, `dir`=1, `locked` stays 1.
4. **Illegal step:** locked UP at 2, feed 2 (hold), then 5.
   - Two `step_err` pulses, `err_count`=2.
   - State is ACQ, `locked`=0.
   - Relock requires 2 further UP steps.
5. **Saturation:** ERR_W=2, inject 5 illegal steps.
   - `err_count` goes 1,2,3,3,3.
   - `step_err` pulses all 5 times.
6. **Reset mid-operation:** assert `clear_n`=0 asynchronously while locked.
   - All outputs go to 0 without waiting for a clock edge.
   - After release, feed 6,0: the first sample is a capture only, the second gives a `step_err`.
